// File: rtl/ascon_permutation_finale_pkg.sv
// Shared types and lookup tables for the ASCON single-round permutation datapath.
package ascon_pack;

  typedef logic [63:0] type_state [0:4];

  // Round constants indexed by round counter; indices 12..15 add nothing.
  localparam logic [7:0] RoundConst [16] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87,
    8'h78, 8'h69, 8'h5A, 8'h4B, 8'h00, 8'h00, 8'h00, 8'h00
  };

  localparam logic [4:0] SboxTable [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_permutation_finale_sbox.sv
// 5-bit ASCON S-box lookup; bit 4 of the input carries x0.
module sbox_5bit
  import ascon_pack::*;
(
  input  logic [4:0] sbox_i,
  output logic [4:0] sbox_o
);

  always_comb begin
    sbox_o = SboxTable[sbox_i];
  end

endmodule

// File: rtl/ascon_permutation_finale.sv
// One ASCON round per enabled cycle with input/output key, data and domain XORs.
// Optional decrypt behaviour is built when ASCON_DECRYPT_EN is defined.
module ascon_permutation_finale
  import ascon_pack::*;
(
  input  logic         clock_i,
  input  logic         reset_i,
  input  type_state    state_i,
  input  logic         data_sel_i,
  input  logic [3:0]   counter_i,
  input  logic [63:0]  data_i,
  input  logic [127:0] key_i,
  input  logic         en_xor_data_i,
  input  logic         en_data_i,
  input  logic         en_xor_key_i,
  input  logic         en_xor_key_end_i,
  input  logic         en_xor_lsb_i,
  input  logic         en_reg_state_i,
  input  logic         en_cipher_i,
  output logic [63:0]  cipher_o,
  output logic [127:0] tag_o
);

  type_state   state_q, state_d;
  type_state   x_mux, x_begin, x_rc, x_sbox, x_lin, x_end;
  logic [63:0] cipher_q, cipher_d;
  logic [4:0]  sbox_in  [64];
  logic [4:0]  sbox_out [64];

`ifndef ASCON_DECRYPT_EN
  logic unused_en_data;
  assign unused_en_data = en_data_i;
`endif

  always_comb begin : p_begin
    for (int i = 0; i < 5; i++) begin
      x_mux[i] = data_sel_i ? state_q[i] : state_i[i];
    end
    x_begin = x_mux;
    if (en_xor_data_i) begin
      x_begin[0] = x_mux[0] ^ data_i;
    end
    cipher_d = en_cipher_i ? x_begin[0] : cipher_q;
`ifdef ASCON_DECRYPT_EN
    // Decrypt: ciphertext word replaces x0, the recovered plaintext is captured.
    if (en_data_i) begin
      x_begin[0] = data_i;
      cipher_d   = en_cipher_i ? (x_mux[0] ^ data_i) : cipher_q;
    end
`endif
    if (en_xor_key_i) begin
      x_begin[1] = x_begin[1] ^ key_i[127:64];
      x_begin[2] = x_begin[2] ^ key_i[63:0];
    end
    x_rc = x_begin;
    x_rc[2][7:0] = x_begin[2][7:0] ^ RoundConst[counter_i];
  end

  always_comb begin : p_sbox_scatter
    for (int j = 0; j < 64; j++) begin
      sbox_in[j] = {x_rc[0][j], x_rc[1][j], x_rc[2][j], x_rc[3][j], x_rc[4][j]};
    end
  end

  for (genvar j = 0; j < 64; j++) begin : g_sbox
    sbox_5bit u_sbox (
      .sbox_i (sbox_in[j]),
      .sbox_o (sbox_out[j])
    );
  end

  always_comb begin : p_end
    x_sbox = '{default: '0};
    for (int j = 0; j < 64; j++) begin
      for (int i = 0; i < 5; i++) begin
        x_sbox[i][j] = sbox_out[j][4-i];
      end
    end
    x_lin[0] = x_sbox[0] ^ ror64(x_sbox[0], 19) ^ ror64(x_sbox[0], 28);
    x_lin[1] = x_sbox[1] ^ ror64(x_sbox[1], 61) ^ ror64(x_sbox[1], 39);
    x_lin[2] = x_sbox[2] ^ ror64(x_sbox[2], 1)  ^ ror64(x_sbox[2], 6);
    x_lin[3] = x_sbox[3] ^ ror64(x_sbox[3], 10) ^ ror64(x_sbox[3], 17);
    x_lin[4] = x_sbox[4] ^ ror64(x_sbox[4], 7)  ^ ror64(x_sbox[4], 41);
    x_end = x_lin;
    if (en_xor_key_end_i) begin
      x_end[3] = x_lin[3] ^ key_i[127:64];
      x_end[4] = x_lin[4] ^ key_i[63:0];
    end
    if (en_xor_lsb_i) begin
      x_end[4][0] = ~x_end[4][0];
    end
    for (int i = 0; i < 5; i++) begin
      state_d[i] = en_reg_state_i ? x_end[i] : state_q[i];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= '{default: '0};
      cipher_q <= '0;
    end else begin
      state_q  <= state_d;
      cipher_q <= cipher_d;
    end
  end

  assign cipher_o = cipher_q;
  assign tag_o    = {state_q[3], state_q[4]};

endmodule

// File: tb/tb_ascon_permutation_finale.sv
// Bench for ascon_permutation_finale: fixed vectors, ASCON-128 init sequence, random rounds.
module tb_ascon_permutation_finale;
  import ascon_pack::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  type_state    st_in;
  logic         sel;
  logic [3:0]   ctr;
  logic [63:0]  data;
  logic [127:0] key;
  logic         xd, en_data, xk, xke, lsb, en_reg, en_ci;
  logic [63:0]  cipher;
  logic [127:0] tag;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] m_st [5];
  logic [63:0] m_ci;

  ascon_permutation_finale dut (
    .clock_i          (clk),
    .reset_i          (rst),
    .state_i          (st_in),
    .data_sel_i       (sel),
    .counter_i        (ctr),
    .data_i           (data),
    .key_i            (key),
    .en_xor_data_i    (xd),
    .en_data_i        (en_data),
    .en_xor_key_i     (xk),
    .en_xor_key_end_i (xke),
    .en_xor_lsb_i     (lsb),
    .en_reg_state_i   (en_reg),
    .en_cipher_i      (en_ci),
    .cipher_o         (cipher),
    .tag_o            (tag)
  );

  typedef struct {
    logic [3:0]      ctr;
    logic [63:0]     data;
    logic            xd, xke, lsb, en_reg, en_ci;
    logic [127:0]    exp_tag;
    logic [63:0]     exp_ci;
    logic            chk_x;
    logic [4:0][63:0] exp_x;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Round constants follow the arithmetic pattern F0 - 0F*i for the first 12 rounds.
  function automatic logic [7:0] rc(input logic [3:0] c);
    return (c < 4'd12) ? 8'hF0 - 8'(c) * 8'h0F : 8'h00;
  endfunction

  // Reference round: bitsliced S-box equations from the ASCON design document.
  task automatic model_tick();
    logic [63:0] x [5];
    logic [63:0] t [5];
    logic [63:0] ci;
    int ra [5] = '{19, 61, 1, 10, 7};
    int rb [5] = '{28, 39, 6, 17, 41};
    if (rst) begin
      for (int i = 0; i < 5; i++) m_st[i] = '0;
      m_ci = '0;
      return;
    end
    for (int i = 0; i < 5; i++) x[i] = sel ? m_st[i] : st_in[i];
    ci = xd ? x[0] ^ data : x[0];
`ifdef ASCON_DECRYPT_EN
    if (en_data) ci = x[0] ^ data;
    x[0] = en_data ? data : ci;
`else
    x[0] = ci;
`endif
    if (xk) begin
      x[1] ^= key[127:64];
      x[2] ^= key[63:0];
    end
    x[2] ^= {56'h0, rc(ctr)};
    x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
    for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
    for (int i = 0; i < 5; i++) x[i] ^= t[(i + 1) % 5];
    x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
    for (int i = 0; i < 5; i++) x[i] = x[i] ^ ror(x[i], ra[i]) ^ ror(x[i], rb[i]);
    if (xke) begin
      x[3] ^= key[127:64];
      x[4] ^= key[63:0];
    end
    if (lsb) x[4][0] = ~x[4][0];
    if (en_reg) for (int i = 0; i < 5; i++) m_st[i] = x[i];
    if (en_ci) m_ci = ci;
  endtask

  task automatic step(input string name);
    model_tick();
    @(posedge clk);
    #1;
    check({name, "_tag"}, tag, {m_st[3], m_st[4]});
    check({name, "_cipher"}, {64'h0, cipher}, {64'h0, m_ci});
  endtask

  task automatic idle_inputs();
    rst = 1'b0; sel = 1'b0; ctr = '0; data = '0;
    xd = 1'b0; en_data = 1'b0; xk = 1'b0; xke = 1'b0; lsb = 1'b0;
    en_reg = 1'b0; en_ci = 1'b0;
    for (int i = 0; i < 5; i++) st_in[i] = '0;
  endtask

  localparam logic [127:0] KeyT = 128'h000102030405060708090A0B0C0D0E0F;

  logic [127:0] held_tag;

  initial begin
    idle_inputs();
    key = KeyT;

    vecs[0] = '{ctr: 4'd0, data: 64'h0, xd: 1'b0, xke: 1'b0, lsb: 1'b0, en_reg: 1'b1,
                en_ci: 1'b0, exp_tag: {64'h3C780000000000F0, 64'h0}, exp_ci: 64'h0,
                chk_x: 1'b1,
                exp_x: {64'h0, 64'h3C780000000000F0, 64'h3FFFFFFFFFFFFF74,
                        64'h00000001E0000770, 64'h001E0F00000000F0}};
    vecs[1] = '{ctr: 4'd0, data: 64'h0, xd: 1'b0, xke: 1'b1, lsb: 1'b1, en_reg: 1'b1,
                en_ci: 1'b0, exp_tag: {64'h3C790203040506F7, 64'h08090A0B0C0D0E0E},
                exp_ci: 64'h0, chk_x: 1'b0, exp_x: '0};
    vecs[2] = '{ctr: 4'd0, data: 64'h0123456789ABCDEF, xd: 1'b1, xke: 1'b0, lsb: 1'b0,
                en_reg: 1'b0, en_ci: 1'b1,
                exp_tag: {64'h3C790203040506F7, 64'h08090A0B0C0D0E0E},
                exp_ci: 64'h0123456789ABCDEF, chk_x: 1'b0, exp_x: '0};
    vecs[3] = '{ctr: 4'd12, data: 64'h0, xd: 1'b0, xke: 1'b0, lsb: 1'b0, en_reg: 1'b1,
                en_ci: 1'b0, exp_tag: 128'h0, exp_ci: 64'h0123456789ABCDEF, chk_x: 1'b1,
                exp_x: {64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0}};
    vecs[4] = '{ctr: 4'd15, data: 64'h0, xd: 1'b0, xke: 1'b1, lsb: 1'b1, en_reg: 1'b1,
                en_ci: 1'b0, exp_tag: {64'h0001020304050607, 64'h08090A0B0C0D0E0E},
                exp_ci: 64'h0123456789ABCDEF, chk_x: 1'b0, exp_x: '0};

    // Reset with every enable active: reset must win.
    rst = 1'b1; en_reg = 1'b1; en_ci = 1'b1; xd = 1'b1; data = 64'hDEAD_BEEF_0000_1111;
    model_tick();
    @(posedge clk); #1;
    check("reset_tag", tag, 128'h0);
    check("reset_cipher", {64'h0, cipher}, 128'h0);

    // Fixed vectors from zero external state.
    for (int v = 0; v < 5; v++) begin
      idle_inputs();
      key = KeyT; ctr = vecs[v].ctr; data = vecs[v].data; xd = vecs[v].xd;
      xke = vecs[v].xke; lsb = vecs[v].lsb; en_reg = vecs[v].en_reg; en_ci = vecs[v].en_ci;
      model_tick();
      @(posedge clk); #1;
      check($sformatf("vec%0d_tag", v), tag, vecs[v].exp_tag);
      check($sformatf("vec%0d_cipher", v), {64'h0, cipher}, {64'h0, vecs[v].exp_ci});
      if (vecs[v].chk_x) begin
        for (int i = 0; i < 5; i++) begin
          check($sformatf("vec%0d_x%0d", v, i), {64'h0, dut.state_q[i]},
                {64'h0, vecs[v].exp_x[i]});
        end
      end
    end

    // Hold: no state load while other inputs churn.
    held_tag = {64'h0001020304050607, 64'h08090A0B0C0D0E0E};
    for (int k = 0; k < 4; k++) begin
      idle_inputs();
      key = {$urandom, $urandom, $urandom, $urandom};
      sel = k[0]; ctr = 4'($urandom); xk = 1'b1; xke = 1'b1; lsb = 1'b1;
      for (int i = 0; i < 5; i++) st_in[i] = {$urandom, $urandom};
      step($sformatf("hold%0d", k));
      check($sformatf("hold%0d_const", k), tag, held_tag);
    end

    // Mux: with data_sel=1 the external state must not matter.
    for (int k = 0; k < 3; k++) begin
      idle_inputs();
      key = KeyT; sel = 1'b1; ctr = 4'(k); en_reg = 1'b1;
      for (int i = 0; i < 5; i++) st_in[i] = {$urandom, $urandom};
      step($sformatf("mux%0d", k));
    end

    // Reset in the middle of a permutation.
    for (int r = 0; r < 4; r++) begin
      idle_inputs();
      key = KeyT; sel = (r != 0); ctr = 4'(r); en_reg = 1'b1; en_ci = 1'b1;
      st_in[0] = 64'h80400C0600000000; st_in[1] = KeyT[127:64]; st_in[2] = KeyT[63:0];
      rst = (r == 3);
      step($sformatf("midrst%0d", r));
    end
    check("midrst_tag_zero", tag, 128'h0);

    // ASCON-128 initialization: 12 rounds, key added at the end of the last one.
    key = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    for (int r = 0; r < 12; r++) begin
      idle_inputs();
      sel = (r != 0); ctr = 4'(r); en_reg = 1'b1; en_ci = 1'b1; xke = (r == 11);
      st_in[0] = 64'h80400C0600000000; st_in[1] = key[127:64]; st_in[2] = key[63:0];
      st_in[3] = 64'h0001020304050607; st_in[4] = 64'h08090A0B0C0D0E0F;
      step($sformatf("init_r%0d", r));
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("init_final_x%0d", i), {64'h0, dut.state_q[i]}, {64'h0, m_st[i]});
    end

    // Random rounds.
    for (int k = 0; k < 300; k++) begin
      rst = ($urandom_range(0, 15) == 0);
      sel = 1'($urandom); ctr = 4'($urandom);
      data = {$urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      xd = 1'($urandom); en_data = 1'($urandom); xk = 1'($urandom);
      xke = 1'($urandom); lsb = 1'($urandom);
      en_reg = ($urandom_range(0, 3) != 0); en_ci = 1'($urandom);
      for (int i = 0; i < 5; i++) st_in[i] = {$urandom, $urandom};
      step($sformatf("rand%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ascon_permutation_finale.md
# ascon_permutation_finale

Single-round ASCON-128 permutation datapath with the input/output XOR stages needed for initialization, data processing and finalization. Each enabled clock cycle applies one round (data/key XOR, round-constant addition, substitution, linear diffusion, end-of-round key/domain XOR) and stores the result in the 320-bit state register. It sits under the ASCON FSM, which sequences `counter_i` and the enables. The block also exposes the ciphertext word and the 128-bit tag.

## Interface
- No parameters.
- `clock_i` in 1: single clock, rising edge.
- `reset_i` in 1: synchronous reset, active-high.
- `state_i` in `type_state` (5×64): external initial state.
- `data_sel_i` in 1: 0 = round input is `state_i`; 1 = round input is the state register.
- `counter_i` in 4: round index, selects the round constant.
- `data_i` in 64: plaintext/associated-data word.
- `key_i` in 128: key K, with K_hi = [127:64] and K_lo = [63:0].
- `en_xor_data_i` in 1: x0 ^= `data_i` at round input.
- `en_data_i` in 1: decrypt select, see Configuration.
- `en_xor_key_i` in 1: x1 ^= K_hi and x2 ^= K_lo at round input.
- `en_xor_key_end_i` in 1: x3 ^= K_hi and x4 ^= K_lo at round output.
- `en_xor_lsb_i` in 1: x4[0] ^= 1 at round output.
- `en_reg_state_i` in 1: state register load enable.
- `en_cipher_i` in 1: cipher register load enable.
- `cipher_o` out 64: registered x0 after the input XOR.
- `tag_o` out 128: {state_q[3], state_q[4]}.

## Operation
Combinational path, with x0..x4 = state words 0..4:
- **Mux.** s = `data_sel_i` ? `state_q` : `state_i`.
- **XOR-begin.** Apply the data XOR if enabled, then the key XOR if enabled. Both XORs may be active in the same cycle.
- **Constant addition.** x2[7:0] ^= RC[`counter_i`].
  - RC for 0..11 = F0, E1, D2, C3, B4, A5, 96, 87, 78, 69, 5A, 4B.
  - `counter_i` 12..15 gives constant 00.
- **Substitution.** For each bit j, the 5-bit value {x0[j], x1[j], x2[j], x3[j], x4[j]} (x0 is the MSB) passes through the ASCON S-box: 04 0B 1F 14 1A 15 09 02 1B 05 08 12 1D 03 06 1C 1E 13 07 0E 00 0D 11 18 10 0C 01 19 16 0A 0F 17.
- **Linear layer.** xi ^= ror(xi,a) ^ ror(xi,b), with (a,b) = x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41).
- **XOR-end.** Apply the key-end XOR if enabled, then the LSB XOR if enabled.

Registers:
- `state_q` loads the XOR-end result when `en_reg_state_i`=1, otherwise it holds.
- `cipher_q` loads the XOR-begin x0 when `en_cipher_i`=1, otherwise it holds.

## Timing
- Reset (`reset_i`=1 at a rising edge) clears `state_q` and `cipher_q` to 0, so `tag_o`=0 and `cipher_o`=0. Reset has priority over all enables, including mid-permutation.
- One round per cycle. `state_q` is valid 1 cycle after the edge at which the inputs were applied.
- A 12-round permutation takes 12 cycles:
  - First cycle: `data_sel_i`=0, `counter_i`=0.
  - Following cycles: `data_sel_i`=1, `counter_i` incrementing.
- `tag_o` is combinational from `state_q`, so it is valid in the cycle after the last round.
- `cipher_o` updates 1 cycle after the `en_cipher_i` edge.
- No handshake. Enables are sampled only at the rising edge.

## Configuration
- `ASCON_DECRYPT_EN` defined:
  - When `en_data_i`=1, XOR-begin x0 is replaced by `data_i` instead of XORed.
  - In that mode `cipher_q` loads (old x0 ^ `data_i`), i.e. the plaintext.
- Macro undefined: `en_data_i` is ignored and only the encrypt behaviour exists.

## Structure
- Package `ascon_pack` holds:
  - `type_state` (array [0:4] of logic[63:0]).
  - The RC table.
  - The S-box table.
- Natural sub-module: `sbox_5bit` (5-bit lookup), instantiated 64 times.

## Test plan
- **Reset.** Assert `reset_i` for 1 cycle -> `tag_o`=0, `cipher_o`=0.
- **Zero-state round 0.** `state_i`=0, `data_sel_i`=0, `counter_i`=0, no XORs, `en_reg_state_i`=1, one edge -> state =
  - x0 = 001E0F00000000F0
  - x1 = 00000001E0000770
  - x2 = 3FFFFFFFFFFFFF74
  - x3 = 3C780000000000F0
  - x4 = 0
- **Key-end and LSB XOR.** Same stimulus plus `en_xor_key_end_i`=1 and `en_xor_lsb_i`=1, `key_i`=000102030405060708090A0B0C0D0E0F -> `tag_o` = {3C790203040506F7, 08090A0B0C0D0E0E}.
- **Cipher.** `state_i`=0, `en_xor_data_i`=1, `data_i`=0123456789ABCDEF, `en_cipher_i`=1 -> `cipher_o`=0123456789ABCDEF.
- **Hold and mux.** `en_reg_state_i`=0 -> `state_q` unchanged. `data_sel_i`=1 -> `state_i` changes have no effect on the next state.
- **Full initialization.** 12 rounds with `counter_i` 0..11 and `en_xor_key_end_i` on round 11 -> matches the ASCON-128 reference model state, round by round.
